uart_host_rx: RTL
=================

Name: uart_host_rx

Overview:
- Host-side UART receiver: the far end of the SoC serial link.
- Samples the serial line driven by the SoC's UART_TXD output and decodes 8N1 frames.
- Buffers decoded bytes in a show-ahead FIFO so a bench or host-side logic can drain them.
- Reports framing and overrun errors.
- Synthesizable; shares the SoC clock.

Parameters:
- BAUD_DIV, 868, clock cycles per bit (BOARD_CK / baud rate); must be >= 4.
- FIFO_DEPTH, 16, byte FIFO entries; must be a power of 2.
- AW, 4, FIFO address width, log2(FIFO_DEPTH).

Ports:
- XCLK  in  1  clock.
- XRES  in  1  asynchronous active-high reset.
- UART_RXD  in  1  serial line from the SoC; idle high.
- RD_REQ  in  1  pop request; ignored when EMPTY.
- RD_DATA  out  8  head-of-FIFO byte; valid while EMPTY=0.
- EMPTY  out  1  FIFO empty.
- FULL  out  1  FIFO full.
- COUNT  out  AW+1  FIFO occupancy.
- FRAME_ERR  out  1  sticky: a stop bit was sampled low.
- OVERRUN  out  1  sticky: a byte was dropped because the FIFO was full.
- ERR_CLR  in  1  clears FRAME_ERR and OVERRUN.

Behaviour:
- One clock (XCLK); reset is asynchronous and active-high (XRES).
- Reset values:
  - FSM = IDLE; FIFO pointers = 0.
  - EMPTY=1, FULL=0, COUNT=0, RD_DATA=0.
  - FRAME_ERR=0, OVERRUN=0.
  - Both synchronizer flops = 1.
- Reset asserted mid-frame aborts the frame; the partial byte is discarded.
- Input path: UART_RXD passes through a 2-flop synchronizer (rxs). All decisions below use rxs.
- Bit timer: counter counts BAUD_DIV-1 down to 0. It is reloaded on every state entry.
- State IDLE:
  - Waits for rxs=0. On seeing it, loads the timer with BAUD_DIV/2 - 1 and goes to START.
- State START:
  - At timer expiry (mid start bit): if rxs=0, go to DATA with bit index 0.
  - If rxs=1, the event was a glitch; return to IDLE. No error flag is raised.
- State DATA:
  - At each expiry (mid bit), shift rxs into the shift register, LSB first.
  - After bit 7, go to STOP.
- State STOP:
  - At expiry: if rxs=1, push the byte to the FIFO and go to IDLE.
  - If rxs=0, set FRAME_ERR, discard the byte, and go to WAIT_IDLE.
- State WAIT_IDLE:
  - Stays until rxs=1, then goes to IDLE. This prevents a break condition from retriggering a frame.
- Frame latency: the byte is visible (EMPTY falls) 1 cycle after the mid-stop-bit sample. That is about 9.5*BAUD_DIV + 3 cycles after the start-bit falling edge on UART_RXD.
- Back-to-back frames: a new start bit is accepted from the first IDLE cycle. No inter-frame gap is needed beyond the stop bit.
- FIFO:
  - Show-ahead: RD_DATA = mem[rd_ptr] combinationally from registered storage.
  - Pop occurs when RD_REQ=1 and EMPTY=0. RD_REQ while EMPTY is a no-op.
  - Push with FULL=0 is accepted.
  - Push with FULL=1 and a pop in the same cycle is accepted; COUNT is unchanged.
  - Push with FULL=1 and no pop: byte dropped, OVERRUN set, FIFO contents untouched.
  - Simultaneous push and pop when not full: COUNT unchanged. Pointers wrap modulo FIFO_DEPTH.
  - FULL = (COUNT == FIFO_DEPTH); EMPTY = (COUNT == 0).
- Errors:
  - FRAME_ERR and OVERRUN remain set until ERR_CLR=1.
  - If ERR_CLR and a new error event occur in the same cycle, the flag stays set (set wins).
  - Errors never block reception.

Test Plan (BAUD_DIV=16, FIFO_DEPTH=4):
- Single frame: send 0xA5 8N1 -> EMPTY falls ~155 cycles after the start edge; RD_DATA=0xA5; COUNT=1. Pulse RD_REQ -> EMPTY=1, COUNT=0.
- Back-to-back frames: send 0x00, 0xFF, 0x55 with no gap -> read order 0x00, 0xFF, 0x55; FRAME_ERR=0.
- Glitch rejection: drive UART_RXD low for 4 cycles, then high -> no push; FSM returns to IDLE; EMPTY=1.
- Framing error: send 0x3C with the stop bit low, then hold low 40 cycles, then high -> FRAME_ERR=1, nothing pushed. Next frame 0x12 is received correctly. ERR_CLR -> FRAME_ERR=0.
- Overrun: send 5 bytes 0x01..0x05 with no reads -> FULL=1, OVERRUN=1; reads return 0x01..0x04. Repeat the test with RD_REQ asserted in the push cycle of byte 5 -> 0x05 is stored, OVERRUN stays 0.
- Reset mid-frame: assert XRES during bit 4 of 0x81 -> all outputs return to reset values immediately. The remainder of the frame is not decoded as a byte; line high -> IDLE.

Source files
------------

// File: rtl/uart_host_rx.sv
// uart_host_rx: host-side UART receiver for the SoC serial link.
// It decodes 8N1 frames from UART_RXD and queues the bytes in a show-ahead FIFO.
// Framing errors and overruns are reported through sticky flags.
//
// Ports:
//   XCLK       clock (shared with the SoC)
//   XRES       asynchronous active-high reset
//   UART_RXD   serial line from the SoC, idle high
//   RD_REQ     pop request; ignored while EMPTY
//   RD_DATA    head-of-FIFO byte, valid while EMPTY=0
//   EMPTY      FIFO empty
//   FULL       FIFO full
//   COUNT      FIFO occupancy
//   FRAME_ERR  sticky: a stop bit was sampled low
//   OVERRUN    sticky: a byte was dropped because the FIFO was full
//   ERR_CLR    clears FRAME_ERR and OVERRUN (a same-cycle error event wins)
module uart_host_rx #(
  parameter int unsigned BAUD_DIV   = 868,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned AW         = 4
) (
  input  logic          XCLK,
  input  logic          XRES,
  input  logic          UART_RXD,
  input  logic          RD_REQ,
  output logic [7:0]    RD_DATA,
  output logic          EMPTY,
  output logic          FULL,
  output logic [AW:0]   COUNT,
  output logic          FRAME_ERR,
  output logic          OVERRUN,
  input  logic          ERR_CLR
);

  localparam int unsigned TW = $clog2(BAUD_DIV);
  localparam logic [TW-1:0] BIT_LOAD  = TW'(BAUD_DIV - 1);
  localparam logic [TW-1:0] HALF_LOAD = TW'(BAUD_DIV / 2 - 1);
  localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  // Two-flop synchronizer, reset to the idle (high) line level.
  logic rx_meta, rxs;

  always_ff @(posedge XCLK or posedge XRES) begin
    if (XRES) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= UART_RXD;
      rxs     <= rx_meta;
    end
  end

  // Frame decoder
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          expired;
  logic          push;
  logic          frame_err_set;

  assign expired = (timer_q == '0);

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    push          = 1'b0;
    frame_err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d = ST_START;
          timer_d = HALF_LOAD;  // land mid start bit
        end
      end
      ST_START: begin
        if (!expired) begin
          timer_d = timer_q - 1'b1;
        end else if (!rxs) begin
          state_d   = ST_DATA;
          timer_d   = BIT_LOAD;
          bit_idx_d = 3'd0;
        end else begin
          // Line went back high before mid start bit: treat as a glitch.
          state_d = ST_IDLE;
          timer_d = BIT_LOAD;
        end
      end
      ST_DATA: begin
        if (!expired) begin
          timer_d = timer_q - 1'b1;
        end else begin
          shift_d = {rxs, shift_q[7:1]};  // LSB arrives first
          timer_d = BIT_LOAD;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (!expired) begin
          timer_d = timer_q - 1'b1;
        end else begin
          timer_d = BIT_LOAD;
          if (rxs) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            frame_err_set = 1'b1;
            state_d       = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        // Hold off until the line returns high so a break cannot start a frame.
        if (rxs) begin
          state_d = ST_IDLE;
          timer_d = BIT_LOAD;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = BIT_LOAD;
      end
    endcase
  end

  always_ff @(posedge XCLK or posedge XRES) begin
    if (XRES) begin
      state_q   <= ST_IDLE;
      timer_q   <= BIT_LOAD;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // Show-ahead FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  logic          pop, wr_en, overrun_set;

  assign EMPTY   = (count_q == '0);
  assign FULL    = (count_q == DEPTH_C);
  assign COUNT   = count_q;
  assign RD_DATA = mem[rd_ptr_q];

  assign pop         = RD_REQ & ~EMPTY;
  // A full FIFO can still take a byte if a slot frees in the same cycle.
  assign wr_en       = push & (~FULL | pop);
  assign overrun_set = push & FULL & ~pop;

  always_ff @(posedge XCLK or posedge XRES) begin
    if (XRES) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
    end else if (wr_en) begin
      mem[wr_ptr_q] <= shift_q;
    end
  end

  always_ff @(posedge XCLK or posedge XRES) begin
    if (XRES) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky error flags; a new event overrides a same-cycle clear.
  logic frame_err_q, overrun_q;

  always_ff @(posedge XCLK or posedge XRES) begin
    if (XRES) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_err_set | (frame_err_q & ~ERR_CLR);
      overrun_q   <= overrun_set | (overrun_q & ~ERR_CLR);
    end
  end

  assign FRAME_ERR = frame_err_q;
  assign OVERRUN   = overrun_q;

endmodule
